// File: rtl/binario_a_gray_if.sv
// rtl/binario_a_gray_if.sv - control inputs and count outputs of the binary-to-Gray counter
interface binario_a_gray_if #(
  parameter int N = 4
);
  logic         en;
  logic         up;
  logic         load;
  logic [N-1:0] bin_in;
  logic [N-1:0] bin_out;
  logic [N-1:0] gray_out;
  logic         wrap;

  modport master (
    output en,
    output up,
    output load,
    output bin_in,
    input  bin_out,
    input  gray_out,
    input  wrap
  );

  modport slave (
    input  en,
    input  up,
    input  load,
    input  bin_in,
    output bin_out,
    output gray_out,
    output wrap
  );
endinterface

// File: rtl/binario_a_gray.sv
// rtl/binario_a_gray.sv - up/down binary counter with registered Gray code and wrap pulse
module binario_a_gray #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  binario_a_gray_if.slave   bus
);

  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
  localparam logic [N-1:0] ZERO     = {N{1'b0}};

  logic [N-1:0] count_q;
  logic [N-1:0] gray_q;
  logic         wrap_q;

  logic [N-1:0] count_d;
  logic         wrap_d;

  // Next count and wrap flag: load beats count enable; rst is applied in the register.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      count_d = bus.bin_in;
    end else if (bus.en) begin
      if (bus.up) begin
        count_d = count_q + 1'b1;
        wrap_d  = (count_q == ALL_ONES);
      end else begin
        count_d = count_q - 1'b1;
        wrap_d  = (count_q == ZERO);
      end
    end
  end

  // Gray code is registered from the next count so it lines up with bin_out in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= ZERO;
      gray_q  <= ZERO;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      gray_q  <= count_d ^ (count_d >> 1);
      wrap_q  <= wrap_d;
    end
  end

  assign bus.bin_out  = count_q;
  assign bus.gray_out = gray_q;
  assign bus.wrap     = wrap_q;

endmodule
